// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, line levels and clog2 shared by the UART transmitter and receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Ceiling log2, never below 1 so every counter has at least one bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side handshake and line signals of the UART transmitter
interface uart_tx_if #(
  parameter int p_WORD_LEN = 8
);
  logic [p_WORD_LEN-1:0] data;
  logic                  dv;
  logic                  ready;
  logic                  tx;
  logic                  busy;
  logic                  done;

  modport master (output data, dv, input ready, tx, busy, done);
  modport slave  (input data, dv, output ready, tx, busy, done);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running 0..p_CLK_DIV-1 counter, tick at the last count, clearable
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int p_CLK_DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = clog2(p_CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == CW'(p_CLK_DIV - 1));

  // Wrap on the tick, restart from zero on clear so a new frame gets full-length bits
  always_comb cnt_d = (i_clr || o_tick) ? '0 : cnt_q + 1'b1;

  // Counter register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + LSB-first data + optional parity (UART_TX_PARITY_EN) + stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int p_CLK_DIV    = 16,
  parameter int p_WORD_LEN   = 8,
  parameter int p_STOP_BITS  = 1,
  parameter int p_PARITY_ODD = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  uart_tx_if.slave   bus
);
  localparam int BW = clog2(p_WORD_LEN + 1);

  if (p_CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx: p_CLK_DIV must be >= 2");
  end
  if (p_STOP_BITS < 1 || p_STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: p_STOP_BITS must be 1 or 2");
  end
  if (p_WORD_LEN < 1 || p_WORD_LEN > 16) begin : g_bad_len
    $error("uart_tx: p_WORD_LEN must be in 1..16");
  end
  if (p_PARITY_ODD != 0 && p_PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx: p_PARITY_ODD must be 0 or 1");
  end

  uart_state_e           state_q, state_d;
  logic [p_WORD_LEN-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  par_bit;
  logic                  accept;
  logic                  tick;

  assign accept = bus.dv && ready_q;

  uart_baud_gen #(.p_CLK_DIV(p_CLK_DIV)) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (accept),
    .o_tick (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  // Parity is taken from the word as accepted, since the shift register is consumed while sending
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) par_q <= 1'b0;
    else       par_q <= par_d;

  assign par_d   = accept ? ((^bus.data) ^ (p_PARITY_ODD != 0)) : par_q;
  assign par_bit = par_d;
`else
  assign par_bit = LINE_IDLE;
`endif

  // Next-state logic; the line level is derived from the next state so o_tx is a plain register
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_START;
        shift_d = bus.data;
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        bit_d   = '0;
      end
      ST_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BW'(p_WORD_LEN - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
          bit_d   = '0;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP: if (tick) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(p_STOP_BITS - 1)) begin
          state_d = ST_IDLE;
          bit_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_d    = (state_d == ST_START)  ? LINE_START :
              (state_d == ST_DATA)   ? shift_d[0] :
              (state_d == ST_PARITY) ? par_bit    :
              (state_d == ST_STOP)   ? LINE_STOP  : LINE_IDLE;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops the line back to idle at once
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= LINE_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts a parallel word through a valid/ready handshake and serialises it on o_tx as: start bit (0), data LSB first, optional parity, then stop bit(s) (1). Each bit is held for exactly p_CLK_DIV clock cycles. It sits between the host-side data path and the UART pin and shares framing parameters with the receiver.

Parameters:
p_CLK_DIV, 16, clock cycles per baud period (internal freq / baud rate); legal values >= 2
p_WORD_LEN, 8, number of data bits per frame (1..16)
p_STOP_BITS, 1, number of stop bits (1 or 2)
p_PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; asynchronous, active-high
i_data  input  p_WORD_LEN  word to transmit; sampled only on handshake
i_dv  input  1  data valid from host
o_ready  output  1  transmitter can accept a word this cycle
o_tx  output  1  serial line, idles high
o_busy  output  1  frame in progress (any state except IDLE)
o_done  output  1  one-cycle pulse when a frame's last stop bit completes

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_tx=1, o_ready=0, o_busy=0, o_done=0, counters=0, shift register=0. o_ready rises on the first i_clk edge after i_rst deasserts.
- Reset mid-frame: line returns to 1 immediately (async); the partial frame is abandoned, with no o_done.
- Handshake: a word is accepted on the rising edge where i_dv=1 and o_ready=1. i_data is latched into the shift register on that edge. o_ready drops on that edge. i_dv while o_ready=0 is ignored; there is no buffering.
- All outputs are registered; o_tx has no combinational path from inputs.
- FSM states:
  - IDLE: o_tx=1, o_ready=1. On accept -> START.
  - START: o_tx=0 for p_CLK_DIV cycles -> DATA.
  - DATA: o_tx = shift[0] for p_CLK_DIV cycles per bit. Shift right and increment bit count at each bit boundary. After p_WORD_LEN bits -> PARITY if compiled in, else STOP.
  - PARITY: see Optional Feature.
  - STOP: o_tx=1 for p_STOP_BITS*p_CLK_DIV cycles -> IDLE.
- Baud counter runs 0..p_CLK_DIV-1. The bit tick occurs at count p_CLK_DIV-1 and the counter wraps to 0. Counter width is clog2(p_CLK_DIV); bit counter width is clog2(p_WORD_LEN+1).
- Timing: accept at edge k; start bit drives o_tx during cycles k+1..k+p_CLK_DIV.
- o_done and o_ready are both 1 in the first IDLE cycle after STOP. Accepting in that cycle gives back-to-back frames with a frame period of (1+p_WORD_LEN+P+p_STOP_BITS)*p_CLK_DIV + 1 cycles, where P = 1 with parity, else 0.
- Illegal state encodings go to IDLE with o_tx=1.
- Elaboration error if p_CLK_DIV<2, p_STOP_BITS not in {1,2}, or p_WORD_LEN not in 1..16.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: after the data bits, the PARITY state drives one parity bit for p_CLK_DIV cycles. The bit is XOR of the latched word, inverted when p_PARITY_ODD=1. Parity is computed from the word at acceptance, not from the shifting register.
- Undefined: no PARITY state, and p_PARITY_ODD is ignored. This matches a receiver configured with p_WORD_LEN data-only bits.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - clog2 function;
  - line idle/start/stop level constants.
  The receiver reuses this package.
- One sub-module is natural: uart_baud_gen (p_CLK_DIV; inputs i_clk, i_rst, i_clr; output o_tick one cycle at count p_CLK_DIV-1). The transmitter clears it on accept; the receiver reuses it.

Test Plan:
- DIV=4, W=8, no parity; send 0xA5 -> o_tx: 0, 1,0,1,0,0,1,0,1, 1, each exactly 4 cycles; o_done pulses at cycle 41 after accept; o_ready returns 1 with o_done.
- Back-to-back: hold i_dv=1 with 0x00 then 0xFF -> second start bit begins the cycle after o_done; no extra idle beyond 1 cycle; period 41 cycles.
- i_dv pulsed during a frame with 0x3C -> ignored; the transmitted frame is unchanged and only one o_done occurs.
- Async reset asserted mid-DATA (bit 3) -> o_tx=1 immediately, o_ready=0 during reset, 1 one edge after release; no o_done.
- UART_TX_PARITY_EN defined, p_PARITY_ODD=0, send 0xA5 -> parity bit 0; p_PARITY_ODD=1, send 0x07 -> parity bit 0; stop follows after 4 cycles.
- p_STOP_BITS=2, DIV=3, W=5, send 5'b10011 -> 0,1,1,0,0,1 then 1 for 6 cycles; o_done at cycle 25 after accept.
